// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: direct-mapped I-cache fetch with 2-bit BHT prediction,
// feeding a circular instruction queue drained by a ready/valid dispatcher.
module inst_fetch_queue #(
    parameter int IC_IDX_W   = 8,
    parameter int IQ_DEPTH_W = 3,
    parameter int BHT_IDX_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        bht_upd_en,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_ack,
    input  logic [31:0] mc_inst,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_prd_pc
);
    localparam int IC_N  = 2 ** IC_IDX_W;
    localparam int IQ_N  = 2 ** IQ_DEPTH_W;
    localparam int BHT_N = 2 ** BHT_IDX_W;
    localparam int TAG_W = 30 - IC_IDX_W;

    typedef enum logic [1:0] {FETCH, MISS, DROP} state_t;

    state_t                  state;
    logic [31:0]             pc;
    logic [31:0]             ic_data [IC_N];
    logic [TAG_W-1:0]        ic_tag  [IC_N];
    logic [IC_N-1:0]         ic_valid;
    logic [1:0]              bht     [BHT_N];
    logic [31:0]             q_inst  [IQ_N];
    logic [31:0]             q_pc    [IQ_N];
    logic [31:0]             q_prd   [IQ_N];
    logic [IQ_DEPTH_W-1:0]   head, tail;
    logic [IQ_DEPTH_W:0]     cnt;

    logic [IC_IDX_W-1:0]     ic_idx, fill_idx;
    logic [BHT_IDX_W-1:0]    bht_idx, upd_idx;
    logic [31:0]             inst, prd, j_imm, b_imm;
    logic [1:0]              upd_old, upd_new;
    logic                    hit, full, ack, push, pop, miss_start;
    logic                    unused_upd_bits;

    assign id_valid  = cnt != '0;
    assign id_inst   = q_inst[head];
    assign id_pc     = q_pc[head];
    assign id_prd_pc = q_prd[head];
    assign unused_upd_bits = ^{bht_upd_pc[31:BHT_IDX_W+2], bht_upd_pc[1:0]};

    always_comb begin
        ic_idx     = pc[IC_IDX_W+1:2];
        fill_idx   = mc_addr[IC_IDX_W+1:2];
        bht_idx    = pc[BHT_IDX_W+1:2];
        upd_idx    = bht_upd_pc[BHT_IDX_W+1:2];
        hit        = ic_valid[ic_idx] && ic_tag[ic_idx] == pc[31:IC_IDX_W+2];
        full       = cnt[IQ_DEPTH_W];
        ack        = mc_ack && state != FETCH;
        // In MISS the returning word belongs to pc, so it feeds prediction directly
        inst       = state == FETCH ? ic_data[ic_idx] : mc_inst;
        j_imm      = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        b_imm      = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        prd        = inst[6:0] == 7'b1101111 ? pc + j_imm :
                     (inst[6:0] == 7'b1100011 && bht[bht_idx][1]) ? pc + b_imm : pc + 32'd4;
        push       = !flush && (state == FETCH ? hit && !full : state == MISS && mc_ack);
        pop        = id_valid && id_ready;
        miss_start = state == FETCH && !flush && !hit && !full;
        upd_old    = bht[upd_idx];
        upd_new    = bht_upd_taken ? (upd_old == 2'b11 ? 2'b11 : upd_old + 2'b01)
                                   : (upd_old == 2'b00 ? 2'b00 : upd_old - 2'b01);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= '0;
            mc_req   <= 1'b0;
            mc_addr  <= '0;
            ic_valid <= '0;
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
        end else if (rdy) begin
            if (bht_upd_en) bht[upd_idx] <= upd_new;
            // A dropped (flushed) fetch still fills the cache
            if (ack) begin
                ic_data[fill_idx]  <= mc_inst;
                ic_tag[fill_idx]   <= mc_addr[31:IC_IDX_W+2];
                ic_valid[fill_idx] <= 1'b1;
            end
            state   <= ack ? FETCH : (state == MISS && flush) ? DROP : miss_start ? MISS : state;
            mc_req  <= miss_start ? 1'b1 : ack ? 1'b0 : mc_req;
            mc_addr <= miss_start ? pc : mc_addr;
            if (flush) begin
                pc   <= flush_pc;
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                if (push) begin
                    q_inst[tail] <= inst;
                    q_pc[tail]   <= pc;
                    q_prd[tail]  <= prd;
                    tail         <= tail + IQ_DEPTH_W'(1);
                    pc           <= prd;
                end
                if (pop) head <= head + IQ_DEPTH_W'(1);
                cnt <= cnt + (IQ_DEPTH_W+1)'(push) - (IQ_DEPTH_W+1)'(pop);
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed bench with a fixed-latency memory responder
// and a pop/request log checked against hand-computed streams.
module tb_inst_fetch_queue;
    logic        clk = 0, rst = 1, rdy = 0, flush = 0;
    logic [31:0] flush_pc = 0;
    logic        bht_upd_en = 0, bht_upd_taken = 0;
    logic [31:0] bht_upd_pc = 0;
    logic        mc_req, mc_ack, id_valid, id_ready = 0;
    logic [31:0] mc_addr, mc_inst, id_inst, id_pc, id_prd_pc;

    logic        mem_en = 1, mem_ack = 0, force_ack = 0, req_q = 0;
    logic [31:0] mem_inst = 0, force_inst = 0;
    logic [31:0] mem [256];
    int          wcnt = 0, cyc = 0, checks = 0, errors = 0, mark = 0, idx = 0, n40 = 0;
    logic [31:0] pop_pc [$], pop_prd [$], pop_inst [$], req_log [$];
    int          pop_cyc [$];

    localparam logic [31:0] ADDI = 32'h00100093, JAL_M8 = 32'hFF9FF06F, BEQ_40 = 32'h04000063;
    logic [31:0] exp_a_pc  [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h10};
    logic [31:0] exp_a_prd [8] = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h10, 32'h8};
    logic [31:0] exp_req   [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] exp_b_pc  [8] = '{32'hC, 32'h10, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h10};

    assign mc_ack  = mem_ack | force_ack;
    assign mc_inst = force_ack ? force_inst : mem_inst;

    inst_fetch_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .flush_pc(flush_pc),
        .bht_upd_en(bht_upd_en), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
        .mc_req(mc_req), .mc_addr(mc_addr), .mc_ack(mc_ack), .mc_inst(mc_inst),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
        .id_prd_pc(id_prd_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log pops and request starts; answer each request 3 cycles after it rises
    always @(negedge clk) begin
        if (!rst && rdy && !flush && id_valid && id_ready) begin
            pop_pc.push_back(id_pc);
            pop_prd.push_back(id_prd_pc);
            pop_inst.push_back(id_inst);
            pop_cyc.push_back(cyc);
        end
        if (mc_req && !req_q) req_log.push_back(mc_addr);
        req_q = mc_req;
        if (!mem_en || !mc_req) begin
            wcnt = 0;
            mem_ack = 0;
        end else if (rdy) begin
            if (mem_ack) begin
                mem_ack = 0;
                wcnt = 0;
            end else if (wcnt == 2) begin
                mem_ack = 1;
                mem_inst = mem[mc_addr[9:2]];
            end else wcnt++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_pops(input string tag, input int n);
        for (int k = 0; k < 300 && pop_pc.size() < n; k++) step();
        chk(tag, 32'(pop_pc.size() >= n), 32'd1);
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] addr, input int from, output int found);
        found = -1;
        for (int k = 0; k < 300 && found < 0; k++) begin
            for (int j = from; j < pop_pc.size(); j++) if (found < 0 && pop_pc[j] == addr) found = j;
            if (found < 0) step();
        end
        chk(tag, 32'(found >= 0), 32'd1);
        if (found < 0) found = 0;
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush = 1;
        flush_pc = target;
        step();
        flush = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = ADDI;
        mem[4] = JAL_M8;
        mem[8] = BEQ_40;
        rdy = 1;
        step(2);
        chk("reset_id_valid", 32'(id_valid), 0);
        chk("reset_mc_req", 32'(mc_req), 0);
        chk("reset_mc_addr", mc_addr, 0);
        chk("reset_pc", dut.pc, 0);

        // Cold start then loop 0x8..0x10 from the cache
        rst = 0;
        id_ready = 1;
        wait_pops("cold_pops", 8);
        chk("cold_req_count", 32'(req_log.size()), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("cold_req%0d", i), req_log[i], exp_req[i]);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("cold_pc%0d", i), pop_pc[i], exp_a_pc[i]);
            chk($sformatf("cold_prd%0d", i), pop_prd[i], exp_a_prd[i]);
        end
        chk("cold_inst0", pop_inst[0], ADDI);
        chk("jal_inst", pop_inst[4], JAL_M8);
        for (int i = 5; i < 8; i++) chk($sformatf("hit_rate%0d", i), 32'(pop_cyc[i] - pop_cyc[i-1]), 1);

        // Flush during a hit push, then fill the queue with id_ready low
        id_ready = 0;
        do_flush(32'h8);
        chk("flush_hit_valid", 32'(id_valid), 0);
        chk("flush_hit_pc", dut.pc, 32'h8);
        step(12);
        chk("full_pc", dut.pc, 32'h10);
        chk("full_cnt", 32'(dut.cnt), 8);
        chk("full_head", id_pc, 32'h8);
        chk("full_req", 32'(mc_req), 0);
        do_flush(32'hC);
        chk("flush_full_valid", 32'(id_valid), 0);
        chk("flush_full_pc", dut.pc, 32'hC);
        step(12);
        chk("refill_pc", dut.pc, 32'h8);
        mark = pop_pc.size();
        id_ready = 1;
        wait_pops("drain_pops", mark + 8);
        for (int i = 0; i < 8; i++) chk($sformatf("drain_pc%0d", i), pop_pc[mark+i], exp_b_pc[i]);

        // BHT: weakly not-taken, then strongly taken, then back to not-taken
        do_flush(32'h20);
        mark = pop_pc.size();
        wait_pop("br1_seen", 32'h20, mark, idx);
        chk("br1_inst", pop_inst[idx], BEQ_40);
        chk("br1_prd", pop_prd[idx], 32'h24);
        bht_upd_en = 1;
        bht_upd_pc = 32'h20;
        bht_upd_taken = 1;
        step(2);
        bht_upd_en = 0;
        chk("bht_sat_hi", 32'(dut.bht[8]), 3);
        do_flush(32'h20);
        mark = pop_pc.size();
        wait_pop("br2_seen", 32'h20, mark, idx);
        chk("br2_prd", pop_prd[idx], 32'h60);
        bht_upd_en = 1;
        bht_upd_taken = 0;
        step(3);
        bht_upd_en = 0;
        do_flush(32'h20);
        mark = pop_pc.size();
        wait_pop("br3_seen", 32'h20, mark, idx);
        chk("br3_prd", pop_prd[idx], 32'h24);

        // Flush two cycles into a miss at 0x40
        do_flush(32'h40);
        for (int k = 0; k < 50 && !(mc_req && mc_addr == 32'h40); k++) step();
        chk("miss40_seen", 32'(mc_req && mc_addr == 32'h40), 1);
        step();
        do_flush(32'h100);
        mark = pop_pc.size();
        chk("drop_valid", 32'(id_valid), 0);
        chk("drop_req", 32'(mc_req), 1);
        chk("drop_addr", mc_addr, 32'h40);
        step();
        chk("drop_ack_req", 32'(mc_req), 0);
        step();
        chk("redirect_req", 32'(mc_req), 1);
        chk("redirect_addr", mc_addr, 32'h100);
        wait_pop("redirect_seen", 32'h100, mark, idx);
        chk("redirect_first", pop_pc[mark], 32'h100);
        n40 = 0;
        for (int j = mark; j < pop_pc.size(); j++) if (pop_pc[j] == 32'h40) n40++;
        chk("no_dropped_push", 32'(n40), 0);

        // Reset mid-miss, late ack ignored, ack under rdy=0 ignored
        mem_en = 0;
        step(3);
        rst = 1;
        step();
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_req", 32'(mc_req), 0);
        chk("rst_addr", mc_addr, 0);
        chk("rst_pc", dut.pc, 0);
        rst = 0;
        force_ack = 1;
        force_inst = 32'hDEADBEEF;
        step();
        force_ack = 0;
        chk("late_ack_req", 32'(mc_req), 1);
        chk("late_ack_addr", mc_addr, 0);
        chk("late_ack_valid", 32'(id_valid), 0);
        rdy = 0;
        force_ack = 1;
        step();
        force_ack = 0;
        rdy = 1;
        chk("rdy_low_req", 32'(mc_req), 1);
        chk("rdy_low_valid", 32'(id_valid), 0);
        mem_en = 1;
        mark = pop_pc.size();
        wait_pop("post_rst_seen", 32'h0, mark, idx);
        chk("post_rst_inst", pop_inst[idx], ADDI);
        chk("post_rst_prd", pop_prd[idx], 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
